pe_mac_cfg: RTL
===============

Name: pe_mac_cfg

Overview:
- Parametrised successor to the single-mode systolic PE.
- Signed fixed-point multiply-accumulate cell for the MHA systolic matrix-multiply array.
- Generalised in data width and fraction width; adds two run-time dataflow modes:
  - weight-stationary (WS): products summed down the column;
  - output-stationary (OS): products accumulated locally, then drained down the column.
- Sits in an R×C grid. Left/top inputs come from neighbour PEs or the edge feeders; right/down outputs go to neighbours.

Parameters:
- DW, 16: data width of X, W, D and OUT (signed two's complement).
- FRAC, 8: fraction bits. Products are rescaled by >>FRAC.
- ACC_W, 40: OS accumulator width. Must be ≥ 2*DW.

Ports:
- I_CLK  in  1  clock. All logic is on the rising edge.
- I_RST  in  1  synchronous, active-high reset.
- I_MODE  in  1  0 = WS, 1 = OS.
- I_X_VLD  in  1  X valid.
- I_X  in  DW  operand from the left.
- I_W_VLD  in  1  W valid. WS: weight load. OS: streamed operand from the top.
- I_W  in  DW  weight/operand.
- I_D_VLD  in  1  D valid.
- I_D  in  DW  partial sum (WS) or drained result (OS) from above.
- I_CLR  in  1  OS: clear accumulator.
- I_DRAIN  in  1  OS: emit own accumulator.
- O_X_VLD  out  1  forwarded X valid.
- O_X  out  DW  X shifted right.
- O_W_VLD  out  1  forwarded W valid (OS only).
- O_W  out  DW  W shifted down (OS only).
- O_OUT_VLD  out  1  result valid.
- O_OUT  out  DW  result shifted down.
- O_COLLIDE  out  1  one-cycle pulse: pass-through D dropped.

Behaviour:
- Reset: every output and internal register goes to 0, including the weight register, accumulator, pipeline valids and O_COLLIDE. Reset mid-operation aborts in-flight data: no O_OUT_VLD appears on the cycle after reset.
- Forwarding, both modes:
  - O_X/O_X_VLD are I_X/I_X_VLD delayed 1 cycle.
  - OS: O_W/O_W_VLD are I_W/I_W_VLD delayed 1 cycle.
  - WS: O_W_VLD = 0.
- Rounding rule R(v): (v + 2^(FRAC-1)) >>> FRAC, i.e. arithmetic shift, round half up.
- Saturation rule S(v): clamp to [-2^(DW-1), 2^(DW-1)-1].
- WS mode:
  - Weight load: I_W_VLD loads I_W into the weight register. It takes effect for X arriving the following cycle.
  - Stage 1 (cycle t, I_X_VLD=1): register P = I_X*W_reg (2*DW, full precision). Also register D = I_D_VLD ? I_D : 0.
  - Stage 2 (t+1): O_OUT = S(R(P) + sext(D)). O_OUT_VLD=1 at cycle t+2, i.e. latency 2.
  - Back-to-back X every cycle sustains throughput 1/cycle.
  - I_D_VLD without I_X_VLD: D is ignored.
- OS mode:
  - MAC: on a cycle with I_X_VLD & I_W_VLD, ACC ← sat_ACC_W(ACC + I_X*I_W). The accumulator saturates at ACC_W bounds and never wraps.
  - I_CLR: ACC ← 0. I_CLR together with a MAC: ACC ← product (clear first).
  - I_DRAIN: O_OUT = S(R(ACC)) with O_OUT_VLD=1 on the next cycle. ACC is unchanged unless I_CLR is also asserted.
  - I_DRAIN together with a MAC: the drained value excludes that cycle's product.
  - Pass-through: I_D_VLD without I_DRAIN gives O_OUT=I_D, O_OUT_VLD=1 on the next cycle.
  - I_D_VLD & I_DRAIN in the same cycle: own result wins, I_D is dropped, and O_COLLIDE pulses on the next cycle.
- Mode change:
  - I_MODE is registered.
  - Any change clears all pipeline valids, ACC and O_COLLIDE on the following edge.
  - Outputs during the change cycle follow the old mode.
- Unused inputs are ignored: I_CLR and I_DRAIN in WS mode.

Decomposition:
- Shared package mha_pe_pkg:
  - mode constants MODE_WS=1'b0, MODE_OS=1'b1;
  - round_shift and saturate functions, parametrised by width. These are reused by the softmax and layer-norm blocks.
- One sub-module: pe_mul_rs. Registered signed DW×DW multiplier with 2*DW output, one stage, shared by both modes.

Test Plan (DW=16, FRAC=8, Q8.8):
- WS basic: load W=0x0200; then X=0x0180, D=0x0100 with both valids → O_OUT=0x0400, O_OUT_VLD exactly 2 cycles after X; O_X=0x0180 after 1 cycle.
- WS rounding and saturation:
  - W=0x0080, X=0x0001, D=0 → 0x0001.
  - W=0x7FFF, X=0x7FFF → 0x7FFF.
  - W=0x7FFF, X=0x8000 → 0x8000.
- OS accumulate: I_CLR, then 4 cycles of X=0x0100, W=0x0200, then I_DRAIN → O_OUT=0x0800 next cycle. O_W forwarded 0x0200 each cycle.
- OS drain chain and collision:
  - I_D_VLD, I_D=0x1234 → O_OUT=0x1234.
  - Same cycle I_DRAIN with ACC=0x0300 (pre-rescale 0x030000) → O_OUT=0x0300, O_COLLIDE=1 for 1 cycle.
- Reset and mode-switch abort:
  - Assert I_RST the cycle after X valid in WS → no O_OUT_VLD; all outputs 0.
  - Toggle I_MODE with MAC in flight → ACC=0; a subsequent drain gives 0x0000.

Source files
------------

// File: rtl/mha_pe_pkg.sv
// mha_pe_pkg: dataflow mode constants and fixed-point round/saturate helpers shared by the MHA datapath blocks
package mha_pe_pkg;
  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;
  typedef logic signed [63:0] wide_t;
  function automatic wide_t round_shift(input wide_t v, input int frac);
    return (v + (wide_t'(1) <<< (frac - 1))) >>> frac;
  endfunction
  function automatic wide_t saturate(input wide_t v, input int w);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/pe_mac_cfg_if.sv
// pe_mac_cfg_if: left/top inputs and right/down outputs of one systolic PE
interface pe_mac_cfg_if #(parameter int DW = 16);
  logic i_mode, i_x_vld, i_w_vld, i_d_vld, i_clr, i_drain;
  logic signed [DW-1:0] i_x, i_w, i_d;
  logic o_x_vld, o_w_vld, o_out_vld, o_collide;
  logic signed [DW-1:0] o_x, o_w, o_out;
  modport master(output i_mode, i_x_vld, i_x, i_w_vld, i_w, i_d_vld, i_d, i_clr, i_drain,
                 input o_x_vld, o_x, o_w_vld, o_w, o_out_vld, o_out, o_collide);
  modport slave(input i_mode, i_x_vld, i_x, i_w_vld, i_w, i_d_vld, i_d, i_clr, i_drain,
                output o_x_vld, o_x, o_w_vld, o_w, o_out_vld, o_out, o_collide);
endinterface

// File: rtl/pe_mul_rs.sv
// pe_mul_rs: one-stage registered signed multiplier, full 2*DW precision
module pe_mul_rs #(parameter int DW = 16) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [2*DW-1:0] p
);
  always_ff @(posedge clk)
    p <= rst ? '0 : (2*DW)'(a) * (2*DW)'(b);
endmodule

// File: rtl/pe_mac_cfg.sv
// pe_mac_cfg: fixed-point MAC PE with run-time weight-stationary / output-stationary dataflow
module pe_mac_cfg import mha_pe_pkg::*; #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic I_CLK,
  input  logic I_RST,
  pe_mac_cfg_if.slave bus
);
  logic mode_q, p_vld, chg, os;
  logic signed [DW-1:0] w_reg, d_q, mul_b, out_nxt;
  logic signed [2*DW-1:0] p;
  logic signed [ACC_W-1:0] acc, acc_view;
  assign os    = mode_q == MODE_OS;
  assign chg   = bus.i_mode != mode_q;
  assign mul_b = os ? bus.i_w : w_reg;
  pe_mul_rs #(.DW(DW)) u_mul (.clk(I_CLK), .rst(I_RST), .a(bus.i_x), .b(mul_b), .p(p));
  // OS: acc lags the architectural accumulator by the multiplier stage; acc_view folds the pending product back in
  always_comb begin
    acc_view = p_vld ? ACC_W'(saturate(wide_t'(acc) + wide_t'(p), ACC_W)) : acc;
    out_nxt  = os ? (bus.i_drain ? DW'(saturate(round_shift(wide_t'(acc_view), FRAC), DW)) : bus.i_d)
                  : DW'(saturate(round_shift(wide_t'(p), FRAC) + wide_t'(d_q), DW));
  end
  always_ff @(posedge I_CLK)
    if (I_RST) begin
      mode_q        <= MODE_WS;
      p_vld         <= 1'b0;
      w_reg         <= '0;
      d_q           <= '0;
      acc           <= '0;
      bus.o_x_vld   <= 1'b0;
      bus.o_x       <= '0;
      bus.o_w_vld   <= 1'b0;
      bus.o_w       <= '0;
      bus.o_out_vld <= 1'b0;
      bus.o_out     <= '0;
      bus.o_collide <= 1'b0;
    end else begin
      mode_q        <= bus.i_mode;
      bus.o_x_vld   <= bus.i_x_vld;
      bus.o_x       <= bus.i_x;
      bus.o_w_vld   <= os & bus.i_w_vld;
      bus.o_w       <= bus.i_w;
      if (!os && bus.i_w_vld) w_reg <= bus.i_w;
      d_q           <= bus.i_d_vld ? bus.i_d : '0;
      p_vld         <= ~chg & bus.i_x_vld & (~os | bus.i_w_vld);
      acc           <= (chg | (os & bus.i_clr)) ? '0 : os ? acc_view : acc;
      bus.o_out     <= out_nxt;
      bus.o_out_vld <= ~chg & (os ? (bus.i_drain | bus.i_d_vld) : p_vld);
      bus.o_collide <= ~chg & os & bus.i_drain & bus.i_d_vld;
    end
endmodule
